// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity selectors and a vote helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial line and frame config in, decoded byte and status pulses out.
interface uart_rx_if #(
   parameter int DATA_WIDTH = 8
) ();

   logic                  rx_in;
   logic                  par_en;
   logic                  par_typ;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;

   modport master (
      output rx_in,
      output par_en,
      output par_typ,
      input  data_out,
      input  data_valid,
      input  par_err,
      input  stp_err
   );

   modport slave (
      input  rx_in,
      input  par_en,
      input  par_typ,
      output data_out,
      output data_valid,
      output par_err,
      output stp_err
   );

endinterface

// File: rtl/uart_rx_sampler.sv
// Oversampling phase counter and 3-tap majority vote around the bit centre.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic rx_s,
   output logic vote_valid,
   output logic vote_bit,
   output logic wrap
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0] TAP_LO   = CNT_W'(OVERSAMPLE/2 - 1);
   localparam logic [CNT_W-1:0] TAP_MID  = CNT_W'(OVERSAMPLE/2);
   localparam logic [CNT_W-1:0] TAP_HI   = CNT_W'(OVERSAMPLE/2 + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

   logic [CNT_W-1:0] edge_cnt;
   logic             tap_lo;
   logic             tap_mid;

   // restart pins the phase at zero so the first START cycle begins a fresh bit period
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         edge_cnt <= '0;
      end else if (edge_cnt == CNT_LAST) begin
         edge_cnt <= '0;
      end else begin
         edge_cnt <= edge_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tap_lo  <= 1'b1;
         tap_mid <= 1'b1;
      end else begin
         if (edge_cnt == TAP_LO)  tap_lo  <= rx_s;
         if (edge_cnt == TAP_MID) tap_mid <= rx_s;
      end
   end

   // third tap is the live sample, so the vote is ready on the cycle it is taken
   assign vote_valid = !restart && (edge_cnt == TAP_HI);
   assign vote_bit   = majority3(tap_lo, tap_mid, rx_s);
   assign wrap       = !restart && (edge_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronizer, frame FSM, shift register, parity/stop checks and result pulses.
//  state  | meaning
//  IDLE   | line idle; low rx_s starts a frame and latches par_en/par_typ
//  START  | validating start bit; voted 1 is a glitch and returns to IDLE
//  DATA   | shifting DATA_WIDTH payload bits in LSB first
//  PARITY | comparing parity bit against payload; mismatch sets par_flag
//  STOP   | stop bit voted mid-bit; emits exactly one result pulse
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 8
) (
   input  logic      clk,
   input  logic      rst,
   uart_rx_if.slave  bus
);

   localparam int BIT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

   rx_state_t             state;
   rx_state_t             state_nxt;
   logic                  rx_m;
   logic                  rx_s;
   logic                  restart;
   logic                  vote_valid;
   logic                  vote_bit;
   logic                  wrap;
   logic [DATA_WIDTH-1:0] shreg;
   logic [BIT_W-1:0]      bit_cnt;
   logic                  par_flag;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic                  load_cfg;
   logic                  shift_en;
   logic                  par_chk;
   logic                  valid_hit;
   logic                  perr_hit;
   logic                  serr_hit;
   logic                  par_expect;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= bus.rx_in;
         rx_s <= rx_m;
      end
   end

   assign restart = (state == IDLE);

   uart_rx_sampler #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_sampler (
      .clk        (clk),
      .rst        (rst),
      .restart    (restart),
      .rx_s       (rx_s),
      .vote_valid (vote_valid),
      .vote_bit   (vote_bit),
      .wrap       (wrap)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!rx_s) state_nxt = START;
         end
         START: begin
            if (vote_valid && vote_bit) begin
               state_nxt = IDLE;
            end else if (wrap) begin
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (wrap && (bit_cnt == LAST_BIT)) begin
               state_nxt = par_en_q ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (wrap) state_nxt = STOP;
         end
         STOP: begin
            // leave at the vote point so a back-to-back start edge is not missed
            if (vote_valid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load_cfg  = (state == IDLE) && !rx_s;
      shift_en  = (state == DATA) && vote_valid;
      par_chk   = (state == PARITY) && vote_valid;
      serr_hit  = (state == STOP) && vote_valid && !vote_bit;
      perr_hit  = (state == STOP) && vote_valid && vote_bit && par_flag;
      valid_hit = (state == STOP) && vote_valid && vote_bit && !par_flag;
   end

   assign par_expect = (^shreg) ^ (par_typ_q == PAR_ODD);

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg          <= '0;
         bit_cnt        <= '0;
         par_flag       <= 1'b0;
         par_en_q       <= 1'b0;
         par_typ_q      <= PAR_EVEN;
         bus.data_out   <= '0;
         bus.data_valid <= 1'b0;
         bus.par_err    <= 1'b0;
         bus.stp_err    <= 1'b0;
      end else begin
         bus.data_valid <= valid_hit;
         bus.par_err    <= perr_hit;
         bus.stp_err    <= serr_hit;
         if (load_cfg) begin
            par_en_q  <= bus.par_en;
            par_typ_q <= bus.par_typ;
            par_flag  <= 1'b0;
         end
         if (shift_en) begin
            shreg <= {vote_bit, shreg[DATA_WIDTH-1:1]};
         end
         if (par_chk && (vote_bit != par_expect)) begin
            par_flag <= 1'b1;
         end
         if (valid_hit) begin
            bus.data_out <= shreg;
         end
         if (state_nxt != state) begin
            bit_cnt <= '0;
         end else if ((state == DATA) && wrap) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboarded bench for uart_rx_core: frame-level reference model, directed cases plus random frames.
module tb_uart_rx_core;

   localparam int DW = 8;
   localparam int OS = 8;

   typedef struct {
      int         kind;       // 0 = data_valid, 1 = par_err, 2 = stp_err
      logic [7:0] data;
      int         start_cyc;
      int         lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   last_bit_cyc = 0;
   logic [7:0] cur_good = 8'h00;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_if #(.DATA_WIDTH(DW)) bus ();

   uart_rx_core #(
      .DATA_WIDTH (DW),
      .OVERSAMPLE (OS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference: what a frame should produce, derived from frame contents only
   function automatic int model_kind(input logic [7:0] d, input logic pe, input logic pt,
                                     input logic pbit, input logic stop);
      int  ones;
      logic want;
      ones = $countones(d);
      want = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
      if (!stop) return 2;
      if (pe && (pbit != want)) return 1;
      return 0;
   endfunction

   function automatic logic good_parity(input logic [7:0] d, input logic pt);
      return pt ? (($countones(d) % 2) == 0) : (($countones(d) % 2) == 1);
   endfunction

   task automatic idle_bits(input int n);
      repeat (n * OS) begin
         @(negedge clk);
         bus.rx_in = 1'b1;
      end
   endtask

   task automatic send_bit(input logic v, input logic spike);
      for (int i = 0; i < OS; i++) begin
         @(negedge clk);
         if (i == 0) last_bit_cyc = cyc + 1;
         bus.rx_in = (spike && (i == OS/2 + 1)) ? ~v : v;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic pbit, input logic stop, input logic spike,
                             input logic flip, input int idle_n);
      exp_t e;
      bus.par_en  = pe;
      bus.par_typ = pt;
      send_bit(1'b0, spike);
      e.kind      = model_kind(d, pe, pt, pbit, stop);
      e.data      = d;
      e.start_cyc = last_bit_cyc;
      e.lat       = 2 + 1 + (1 + DW + int'(pe)) * OS + OS/2 + 1;
      q.push_back(e);
      for (int i = 0; i < DW; i++) begin
         send_bit(d[i], spike);
         if (flip && i == 0) begin
            bus.par_en  = 1'($urandom_range(0, 1));
            bus.par_typ = 1'($urandom_range(0, 1));
         end
      end
      if (pe) send_bit(pbit, spike);
      send_bit(stop, spike);
      idle_bits(idle_n);
   endtask

   // monitor: pops the scoreboard on every result pulse
   initial begin
      exp_t e;
      int   n;
      int   kind;
      forever begin
         @(negedge clk);
         if (!rst) begin
            n = int'(bus.data_valid) + int'(bus.par_err) + int'(bus.stp_err);
            if (n > 0) begin
               chk("pulse_exclusive", n, 1);
               kind = bus.data_valid ? 0 : (bus.par_err ? 1 : 2);
               if (q.size() == 0) begin
                  chk("unexpected_pulse_kind", kind, -1);
               end else begin
                  e = q.pop_front();
                  chk("pulse_kind", kind, e.kind);
                  chk("latency", cyc - e.start_cyc, e.lat);
                  if (kind == 0) chk("data_out", int'(bus.data_out), int'(e.data));
                  else           chk("data_hold", int'(bus.data_out), int'(cur_good));
                  if (e.kind == 0) cur_good = e.data;
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] d;
      logic       pe, pt, pb, st;
      logic [7:0] rst_frame;
      bus.rx_in   = 1'b1;
      bus.par_en  = 1'b0;
      bus.par_typ = 1'b0;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("reset_data_out", int'(bus.data_out), 0);
      chk("reset_data_valid", int'(bus.data_valid), 0);
      chk("reset_par_err", int'(bus.par_err), 0);
      chk("reset_stp_err", int'(bus.stp_err), 0);
      rst = 1'b0;
      idle_bits(2);

      // basic frame, no parity, 80-cycle latency
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
      // even parity good, then same payload with wrong parity bit
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2);
      // odd parity, bad stop bit
      send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3);
      // bad stop and bad parity together: stop error wins
      send_frame(8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);

      // two-cycle glitch on idle line
      @(negedge clk); bus.rx_in = 1'b0;
      @(negedge clk); bus.rx_in = 1'b0;
      idle_bits(3);
      chk("glitch_no_pulse_pending", q.size(), 0);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);

      // single-sample spike at every bit's vote window
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2);
      send_frame(8'h6E, 1'b1, 1'b1, good_parity(8'h6E, 1'b1), 1'b1, 1'b1, 1'b0, 2);

      // reset during the last data bit of 0x12
      rst_frame = 8'h12;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < DW - 1; i++) send_bit(rst_frame[i], 1'b0);
      for (int i = 0; i < OS; i++) begin
         @(negedge clk);
         bus.rx_in = rst_frame[DW-1];
         if (i == OS - 2) begin
            rst = 1'b1;
            cur_good = 8'h00;
         end
         if (i == OS - 1) begin
            chk("midframe_rst_data_out", int'(bus.data_out), 0);
            chk("midframe_rst_pulses",
                int'(bus.data_valid) + int'(bus.par_err) + int'(bus.stp_err), 0);
            rst = 1'b0;
         end
      end
      send_bit(1'b1, 1'b0);
      idle_bits(3);
      send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);

      // random frames, including back-to-back and mid-frame config changes
      for (int n = 0; n < 40; n++) begin
         d  = 8'($urandom_range(0, 255));
         pe = 1'($urandom_range(0, 1));
         pt = 1'($urandom_range(0, 1));
         pb = ($urandom_range(0, 3) == 0) ? ~good_parity(d, pt) : good_parity(d, pt);
         st = ($urandom_range(0, 6) == 0) ? 1'b0 : 1'b1;
         send_frame(d, pe, pt, pb, st,
                    1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)),
                    st ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 4)));
      end

      for (int i = 0; i < 3000 && q.size() > 0; i++) @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
      idle_bits(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
